// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Combinational helpers only; no state, no backpressure of its own.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] arb_idx_t;

    // Owner after reset, chosen so that requester 0 is searched first.
    localparam arb_idx_t RST_OWNER = 2'd3;

    function automatic logic [NUM_REQ-1:0] idx2oh(input arb_idx_t idx);
        idx2oh      = '0;
        idx2oh[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin find-first: first set request starting just after owner.
// Purely combinational (0 cycles); no flow control.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  arb_idx_t           owner,
    output logic               vld,
    output arb_idx_t           idx
);

    logic [NUM_REQ-1:0] rot;
    arb_idx_t           off;

    // Bit i of rot is the request at search position owner+1+i.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[arb_idx_t'(owner + arb_idx_t'(i) + 2'd1)];
        end
    end

    always_comb begin
        vld = 1'b0;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                vld = 1'b1;
                off = arb_idx_t'(i);
            end
        end
        idx = arb_idx_t'(owner + off + 2'd1);
    end

endmodule

// File: rtl/arb_rr4.sv
// Four-requester round-robin arbiter, registered one-hot grants, zero-bubble handoff.
// Grant appears one edge after request; ARB_HOLD_LIMIT_EN bounds tenure to HOLD_MAX cycles.
// No backpressure: requests are level-held by masters until granted.
module arb_rr4
#(
    parameter int unsigned HOLD_MAX = 8
)
(
    input  logic Clk,
    input  logic Resetl,
    input  logic Req0,
    input  logic Req1,
    input  logic Req2,
    input  logic Req3,
    output logic Gnt0,
    output logic Gnt1,
    output logic Gnt2,
    output logic Gnt3
);
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    arb_idx_t           owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               keep;
    logic               limit_fire;
    logic               pick_vld;
    arb_idx_t           pick_idx;

    assign req = {Req3, Req2, Req1, Req0};

`ifdef ARB_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] others;

    // At the limit the owner is masked out, but only if someone else is waiting.
    assign others     = req & ~idx2oh(owner_q);
    assign limit_fire = busy_q && (hold_cnt_q >= HOLD_LAST) && (|others);
    assign pick_req   = limit_fire ? others : req;

    always_comb begin
        hold_cnt_d = 8'd0;
        if (keep) begin
            hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Resetl) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign limit_fire = 1'b0;
    assign pick_req   = req;
`endif

    rr_pick u_pick (
        .req   (pick_req),
        .owner (owner_q),
        .vld   (pick_vld),
        .idx   (pick_idx)
    );

    assign keep = busy_q && req[owner_q] && !limit_fire;

    always_comb begin
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        if (!keep) begin
            if (pick_vld) begin
                gnt_d   = idx2oh(pick_idx);
                owner_d = pick_idx;
                busy_d  = 1'b1;
            end else begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Resetl) begin
            gnt_q   <= '0;
            owner_q <= RST_OWNER;
            busy_q  <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
        end
    end

    assign Gnt0 = gnt_q[0];
    assign Gnt1 = gnt_q[1];
    assign Gnt2 = gnt_q[2];
    assign Gnt3 = gnt_q[3];

endmodule

// File: tb/tb_arb_rr4.sv
// Directed vector table plus randomized invariant/starvation checks for arb_rr4.
module tb_arb_rr4;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetl;
    logic [3:0] req;
    logic       g0, g1, g2, g3;
    logic [3:0] gnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign gnt = {g3, g2, g1, g0};

    arb_rr4 #(.HOLD_MAX(4)) dut (
        .Clk    (clk),
        .Resetl (resetl),
        .Req0   (req[0]),
        .Req1   (req[1]),
        .Req2   (req[2]),
        .Req3   (req[3]),
        .Gnt0   (g0),
        .Gnt1   (g1),
        .Gnt2   (g2),
        .Gnt3   (g3)
    );

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic step(input logic r, input logic [3:0] q);
        resetl = r;
        req    = q;
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t       vecs[$];
    logic [3:0] nreq;
    logic [3:0] applied;
    logic [3:0] gprev;
    logic [3:0] pend;
    int         wait_t[4];

    initial begin
        resetl = 1'b0;
        req    = 4'b0000;
        @(negedge clk);

        // Reset held with every master requesting: no grant may escape.
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 4'b1111);
            check($sformatf("reset_hold[%0d]", i), gnt, 4'b0000);
        end

        // After reset, owner=3 so master 0 wins; rotation 0,1,2,3,0 without bubbles.
        vecs.push_back(vec_t'{1'b1, 4'b1111, 4'b0001});
        vecs.push_back(vec_t'{1'b1, 4'b1110, 4'b0010});
        vecs.push_back(vec_t'{1'b1, 4'b1101, 4'b0100});
        vecs.push_back(vec_t'{1'b1, 4'b1011, 4'b1000});
        vecs.push_back(vec_t'{1'b1, 4'b0111, 4'b0001});
        vecs.push_back(vec_t'{1'b1, 4'b0000, 4'b0000});
        // Single requester: grant one edge later, held five cycles, then released.
        vecs.push_back(vec_t'{1'b1, 4'b0100, 4'b0100});
        vecs.push_back(vec_t'{1'b1, 4'b0100, 4'b0100});
        vecs.push_back(vec_t'{1'b1, 4'b0100, 4'b0100});
        vecs.push_back(vec_t'{1'b1, 4'b0100, 4'b0100});
        vecs.push_back(vec_t'{1'b1, 4'b0100, 4'b0100});
        vecs.push_back(vec_t'{1'b1, 4'b0000, 4'b0000});
        // Fairness: owner 1 releases and re-requests at once; order 3, 0, then 1.
        vecs.push_back(vec_t'{1'b1, 4'b0010, 4'b0010});
        vecs.push_back(vec_t'{1'b1, 4'b1001, 4'b1000});
        vecs.push_back(vec_t'{1'b1, 4'b1011, 4'b1000});
        vecs.push_back(vec_t'{1'b1, 4'b0011, 4'b0001});
        vecs.push_back(vec_t'{1'b1, 4'b0010, 4'b0010});
        // Owner keeps its grant against competitors while it holds its request.
        vecs.push_back(vec_t'{1'b1, 4'b1111, 4'b0010});
        // Idle leaves owner=1, so the next search starts at master 2.
        vecs.push_back(vec_t'{1'b1, 4'b0000, 4'b0000});
        vecs.push_back(vec_t'{1'b1, 4'b1111, 4'b0100});
        // Reset mid-grant drops it; owner returns to 3.
        vecs.push_back(vec_t'{1'b0, 4'b1111, 4'b0000});
        vecs.push_back(vec_t'{1'b1, 4'b1010, 4'b0010});
        vecs.push_back(vec_t'{1'b1, 4'b0000, 4'b0000});

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].req);
            check($sformatf("vec[%0d] req=%b", i, vecs[i].req), gnt, vecs[i].gnt);
        end

`ifdef ARB_HOLD_LIMIT_EN
        // HOLD_MAX=4: master 0 is forced off after four cycles when master 1 waits.
        step(1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'b0011);
            check($sformatf("hold_lim_g0[%0d]", i), gnt, 4'b0001);
        end
        step(1'b1, 4'b0011);
        check("hold_lim_g1", gnt, 4'b0010);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b0001);
            check($sformatf("hold_sole_g0[%0d]", i), gnt, 4'b0001);
        end
        step(1'b1, 4'b0000);
        check("hold_release", gnt, 4'b0000);
`endif

        // Random traffic: masters raise requests every 10 cycles and drop one cycle after grant.
        pend  = 4'b0000;
        gprev = gnt;
        for (int i = 0; i < 4; i++) wait_t[i] = 0;
        for (int cyc = 0; cyc < 2020; cyc++) begin
            nreq = req & ~gnt;
            if (cyc < 2000 && (cyc % 10) == 0) begin
                nreq = nreq | (4'($urandom_range(0, 15)) & ~gnt);
            end
            for (int i = 0; i < 4; i++) begin
                if (nreq[i] && !req[i]) begin
                    pend[i]   = 1'b1;
                    wait_t[i] = 0;
                end
            end
            applied = nreq;
            step(1'b1, nreq);

            n_cmp++;
            if ($countones(gnt) > 1) begin
                n_bad++;
                $display("FAIL rnd_onehot cyc %0d: got %b required at most one bit", cyc, gnt);
            end
            check($sformatf("rnd_no_req_gnt cyc %0d", cyc), gnt & ~applied, 4'b0000);

            if (gnt != 4'b0000 && gnt != gprev) begin
                for (int i = 0; i < 4; i++) begin
                    if (gnt[i]) begin
                        pend[i] = 1'b0;
                    end else if (pend[i]) begin
                        wait_t[i]++;
                        n_cmp++;
                        if (wait_t[i] > 3) begin
                            n_bad++;
                            $display("FAIL rnd_starve master %0d cyc %0d: waited %0d tenures, limit 3",
                                     i, cyc, wait_t[i]);
                        end
                    end
                end
            end
            gprev = gnt;
        end
        check("rnd_all_served", pend, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
